pe_weight_loader: RTL and testbench

- Write-side master for the PE weight-load port.
- Accepts a flat weight stream over a valid/ready handshake and scatters it into a row of NUM_PE processing elements.
- Each PE receives filter_width x filter_width weights in row-major order, with matching write row/col pointers and a one-hot PE enable.
- Sits between the weight buffer/DMA and the PE array; runs once per layer before ifmap streaming starts.

---
 rtl/pe_weight_loader.sv | 191 +++++++++++++++++++
 tb/tb_pe_weight_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_weight_loader.sv
`default_nettype none
// ============================================================================
//  Module      : pe_weight_loader
//  Description : Write-side master for the PE weight-load port. Accepts a
//                flat weight stream over valid/ready and scatters it into a
//                row of NUM_PE processing elements, K x K weights per PE in
//                row-major order, with row/col pointers and a one-hot PE
//                enable. Runs once per layer before ifmap streaming.
//  Options     : WLOAD_BCAST_EN - adds i_bcast; when set at start, only K*K
//                beats are taken and every write targets all N PEs at once.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_weight_loader #(
  parameter int DATA_WIDTH       = 16,
  parameter int MAX_FILTER_WIDTH = 11,
  parameter int NUM_PE           = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_start,
  input  logic [$clog2(MAX_FILTER_WIDTH):0] i_filter_width,
  input  logic [$clog2(NUM_PE):0]           i_num_pe,
`ifdef WLOAD_BCAST_EN
  input  logic                              i_bcast,
`endif
  input  logic [DATA_WIDTH-1:0]             i_wdata,
  input  logic                              i_wvalid,
  output logic                              o_wready,
  output logic [DATA_WIDTH-1:0]             o_weight_data,
  output logic                              o_weight_valid,
  output logic [$clog2(MAX_FILTER_WIDTH):0] o_wr_w_row_ptr,
  output logic [$clog2(MAX_FILTER_WIDTH):0] o_wr_w_col_ptr,
  output logic [NUM_PE-1:0]                 o_pe_en,
  output logic                              o_busy,
  output logic                              o_done
);

  localparam int LOG_MFW = $clog2(MAX_FILTER_WIDTH);
  localparam int LOG_NPE = $clog2(NUM_PE);
  localparam int KW      = LOG_MFW + 1;
  localparam int NW      = LOG_NPE + 1;
  // PE index needs at least one bit even for a single-PE build
  localparam int PEW     = (LOG_NPE > 0) ? LOG_NPE : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [KW-1:0]         r_k;
  logic [NW-1:0]         r_n;
  logic [KW-1:0]         r_row;
  logic [KW-1:0]         r_col;
  logic [PEW-1:0]        r_pe;
  logic                  r_bcast;

  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_wvalid;
  logic [KW-1:0]         r_row_ptr;
  logic [KW-1:0]         r_col_ptr;
  logic [NUM_PE-1:0]     r_pe_en;

  logic                  w_start_ok;
  logic                  w_start_bcast;
  logic                  w_accept;
  logic                  w_col_last;
  logic                  w_row_last;
  logic                  w_pe_last;
  logic                  w_last_beat;
  logic [NUM_PE-1:0]     w_pe_onehot;
  logic [NUM_PE-1:0]     w_pe_sel;

  // A load request is honoured only with a legal filter side and PE count
  assign w_start_ok = (i_filter_width != '0) &&
                      (i_filter_width <= KW'(MAX_FILTER_WIDTH)) &&
                      (i_num_pe != '0) &&
                      (i_num_pe <= NW'(NUM_PE));

`ifdef WLOAD_BCAST_EN
  assign w_start_bcast = i_bcast;
`else
  assign w_start_bcast = 1'b0;
`endif

  // Ready depends on state only, so the upstream can never form a loop
  assign o_wready = (r_state == S_LOAD);
  assign w_accept = i_wvalid & o_wready;

  assign w_col_last  = (r_col == (r_k - KW'(1)));
  assign w_row_last  = (r_row == (r_k - KW'(1)));
  assign w_pe_last   = (NW'(r_pe) == (r_n - NW'(1)));
  // In broadcast mode one K x K pass loads every PE, so the PE count is moot
  assign w_last_beat = w_accept & w_col_last & w_row_last & (w_pe_last | r_bcast);

  for (genvar g = 0; g < NUM_PE; g++) begin : g_pe_onehot
    assign w_pe_onehot[g] = (NW'(g) == NW'(r_pe));
  end

`ifdef WLOAD_BCAST_EN
  logic [NUM_PE-1:0] w_pe_mask;

  for (genvar g = 0; g < NUM_PE; g++) begin : g_pe_mask
    assign w_pe_mask[g] = (NW'(g) < r_n);
  end

  assign w_pe_sel = r_bcast ? w_pe_mask : w_pe_onehot;
`else
  assign w_pe_sel = w_pe_onehot;
`endif

  // Load FSM: config latch, row/col/pe walk and registered PE write port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_n       <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_pe      <= '0;
      r_bcast   <= 1'b0;
      r_wdata   <= '0;
      r_wvalid  <= 1'b0;
      r_row_ptr <= '0;
      r_col_ptr <= '0;
      r_pe_en   <= '0;
    end else begin
      // Write strobe and enable exist only for the cycle after an accept;
      // data and pointers simply hold otherwise
      r_wvalid <= w_accept;
      r_pe_en  <= w_accept ? w_pe_sel : '0;
      if (w_accept) begin
        r_wdata   <= i_wdata;
        r_row_ptr <= r_row;
        r_col_ptr <= r_col;
      end

      case (r_state)
        S_IDLE: begin
          if (i_start && w_start_ok) begin
            r_k     <= i_filter_width;
            r_n     <= i_num_pe;
            r_bcast <= w_start_bcast;
            r_row   <= '0;
            r_col   <= '0;
            r_pe    <= '0;
            r_state <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (w_accept) begin
            if (w_last_beat) begin
              r_state <= S_DONE;
            end
            if (w_col_last) begin
              r_col <= '0;
              if (w_row_last) begin
                r_row <= '0;
                r_pe  <= r_pe + PEW'(1);
              end else begin
                r_row <= r_row + KW'(1);
              end
            end else begin
              r_col <= r_col + KW'(1);
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_weight_data  = r_wdata;
  assign o_weight_valid = r_wvalid;
  assign o_wr_w_row_ptr = r_row_ptr;
  assign o_wr_w_col_ptr = r_col_ptr;
  assign o_pe_en        = r_pe_en;
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pe_weight_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_weight_loader
//  Description : Directed, table-driven bench for pe_weight_loader. Covers
//                reset state, a full K=3/N=2 load, valid gaps, illegal
//                starts, K=1 across all PEs, reset mid-load, i_start during a
//                load and (with WLOAD_BCAST_EN) broadcast loading.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_weight_loader;

  localparam int DW = 16;
  localparam int KW = 5;
  localparam int NW = 4;
  localparam int NP = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start;
  logic [KW-1:0] i_filter_width;
  logic [NW-1:0] i_num_pe;
  logic          tb_bcast;
  logic [DW-1:0] i_wdata;
  logic          i_wvalid;
  logic          o_wready;
  logic [DW-1:0] o_weight_data;
  logic          o_weight_valid;
  logic [KW-1:0] o_wr_w_row_ptr;
  logic [KW-1:0] o_wr_w_col_ptr;
  logic [NP-1:0] o_pe_en;
  logic          o_busy;
  logic          o_done;

  int n_vec = 0;
  int n_err = 0;

  pe_weight_loader #(
    .DATA_WIDTH       (DW),
    .MAX_FILTER_WIDTH (11),
    .NUM_PE           (NP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_start        (i_start),
    .i_filter_width (i_filter_width),
    .i_num_pe       (i_num_pe),
`ifdef WLOAD_BCAST_EN
    .i_bcast        (tb_bcast),
`endif
    .i_wdata        (i_wdata),
    .i_wvalid       (i_wvalid),
    .o_wready       (o_wready),
    .o_weight_data  (o_weight_data),
    .o_weight_valid (o_weight_valid),
    .o_wr_w_row_ptr (o_wr_w_row_ptr),
    .o_wr_w_col_ptr (o_wr_w_col_ptr),
    .o_pe_en        (o_pe_en),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [NP-1:0] pe_en;
    logic [KW-1:0] row;
    logic [KW-1:0] col;
    logic          done;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full load with per-beat expectations; optionally pulses an illegal
  // mid-load i_start (K=5) together with beat 'poke'
  task automatic do_load(input int k, input int n, input logic [DW-1:0] base,
                         input int poke);
    int total;
    int pe;
    logic [NP-1:0] exp_en;
    total = tb_bcast ? k * k : k * k * n;
    i_filter_width = KW'(k);
    i_num_pe       = NW'(n);
    i_start        = 1'b1;
    tick();
    i_start = 1'b0;
    for (int j = 0; j < total; j++) begin
      chk("ld_wready", j, 32'(o_wready), 32'd1);
      i_wvalid = 1'b1;
      i_wdata  = base + DW'(j);
      if (j == poke) begin
        i_start        = 1'b1;
        i_filter_width = KW'(5);
      end
      tick();
      i_start        = 1'b0;
      i_filter_width = KW'(k);
      pe     = j / (k * k);
      exp_en = tb_bcast ? NP'((1 << n) - 1) : NP'(1 << pe);
      chk("ld_valid", j, 32'(o_weight_valid), 32'd1);
      chk("ld_data",  j, 32'(o_weight_data),  32'(base + DW'(j)));
      chk("ld_pe_en", j, 32'(o_pe_en),        32'(exp_en));
      chk("ld_row",   j, 32'(o_wr_w_row_ptr), 32'((j % (k * k)) / k));
      chk("ld_col",   j, 32'(o_wr_w_col_ptr), 32'(j % k));
      chk("ld_done",  j, 32'(o_done),         32'(j == total - 1));
    end
    i_wvalid = 1'b0;
    chk("ld_wready_end", 0, 32'(o_wready), 32'd0);
    tick();
    chk("ld_busy_end", 0, 32'(o_busy), 32'd0);
    chk("ld_done_end", 0, 32'(o_done), 32'd0);
  endtask

  initial begin
    for (int j = 0; j < 18; j++) begin
      tbl[j].data  = DW'(j + 1);
      tbl[j].pe_en = NP'(1 << (j / 9));
      tbl[j].row   = KW'((j % 9) / 3);
      tbl[j].col   = KW'(j % 3);
      tbl[j].done  = (j == 17);
    end

    reset          = 1'b1;
    i_start        = 1'b0;
    i_filter_width = '0;
    i_num_pe       = '0;
    tb_bcast       = 1'b0;
    i_wdata        = '0;
    i_wvalid       = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_wready", 0, 32'(o_wready),       32'd0);
    chk("rst_valid",  0, 32'(o_weight_valid), 32'd0);
    chk("rst_pe_en",  0, 32'(o_pe_en),        32'd0);
    chk("rst_busy",   0, 32'(o_busy),         32'd0);
    chk("rst_done",   0, 32'(o_done),         32'd0);
    chk("rst_data",   0, 32'(o_weight_data),  32'd0);
    chk("rst_row",    0, 32'(o_wr_w_row_ptr), 32'd0);
    chk("rst_col",    0, 32'(o_wr_w_col_ptr), 32'd0);

    // K=3, N=2, continuous stream 1..18 from the vector table
    i_filter_width = KW'(3);
    i_num_pe       = NW'(2);
    i_start        = 1'b1;
    tick();
    i_start = 1'b0;
    chk("t1_busy", 0, 32'(o_busy), 32'd1);
    for (int j = 0; j < 18; j++) begin
      chk("t1_wready", j, 32'(o_wready), 32'd1);
      i_wvalid = 1'b1;
      i_wdata  = tbl[j].data;
      tick();
      chk("t1_valid", j, 32'(o_weight_valid), 32'd1);
      chk("t1_data",  j, 32'(o_weight_data),  32'(tbl[j].data));
      chk("t1_pe_en", j, 32'(o_pe_en),        32'(tbl[j].pe_en));
      chk("t1_row",   j, 32'(o_wr_w_row_ptr), 32'(tbl[j].row));
      chk("t1_col",   j, 32'(o_wr_w_col_ptr), 32'(tbl[j].col));
      chk("t1_done",  j, 32'(o_done),         32'(tbl[j].done));
    end
    // An extra word offered during DONE must not be taken
    chk("t1_wready_done", 0, 32'(o_wready), 32'd0);
    chk("t1_busy_done",   0, 32'(o_busy),   32'd1);
    i_wdata = 16'hDEAD;
    tick();
    i_wvalid = 1'b0;
    chk("t1_busy_after",  0, 32'(o_busy),         32'd0);
    chk("t1_valid_after", 0, 32'(o_weight_valid), 32'd0);
    chk("t1_pe_en_after", 0, 32'(o_pe_en),        32'd0);

    // K=2, N=1, i_wvalid toggling 1/0
    i_filter_width = KW'(2);
    i_num_pe       = NW'(1);
    i_start        = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      i_wvalid = (c % 2 == 0);
      i_wdata  = DW'(16'h20 + c / 2 + 1);
      tick();
      if (c % 2 == 0) begin
        chk("t2_valid", c, 32'(o_weight_valid), 32'd1);
        chk("t2_data",  c, 32'(o_weight_data),  32'(16'h20 + c / 2 + 1));
        chk("t2_pe_en", c, 32'(o_pe_en),        32'd1);
        chk("t2_row",   c, 32'(o_wr_w_row_ptr), 32'((c / 2) / 2));
        chk("t2_col",   c, 32'(o_wr_w_col_ptr), 32'((c / 2) % 2));
        chk("t2_done",  c, 32'(o_done),         32'(c == 6));
      end else begin
        chk("t2_idle_valid", c, 32'(o_weight_valid), 32'd0);
        chk("t2_idle_pe_en", c, 32'(o_pe_en),        32'd0);
        chk("t2_idle_done",  c, 32'(o_done),         32'd0);
      end
    end
    chk("t2_busy_end", 0, 32'(o_busy), 32'd0);
    i_wvalid = 1'b0;

    // Illegal starts: K=0, K=12, N=0, N=9
    begin
      int ill_k [4] = '{0, 12, 3, 3};
      int ill_n [4] = '{1, 1, 0, 9};
      for (int i = 0; i < 4; i++) begin
        i_filter_width = KW'(ill_k[i]);
        i_num_pe       = NW'(ill_n[i]);
        i_start        = 1'b1;
        i_wvalid       = 1'b1;
        tick();
        i_start = 1'b0;
        chk("t3_busy",   i, 32'(o_busy),   32'd0);
        chk("t3_wready", i, 32'(o_wready), 32'd0);
        tick();
        chk("t3_valid",  i, 32'(o_weight_valid), 32'd0);
        i_wvalid = 1'b0;
      end
    end

    // K=1 across all 8 PEs
    do_load(1, 8, 16'h100, -1);

    // Reset after 5 of 9 beats, then a fresh load
    i_filter_width = KW'(3);
    i_num_pe       = NW'(1);
    i_start        = 1'b1;
    tick();
    i_start = 1'b0;
    for (int j = 0; j < 5; j++) begin
      i_wvalid = 1'b1;
      i_wdata  = DW'(16'h40 + j);
      tick();
    end
    chk("t4_pre_row", 0, 32'(o_wr_w_row_ptr), 32'd1);
    chk("t4_pre_col", 0, 32'(o_wr_w_col_ptr), 32'd1);
    reset = 1'b1;
    tick();
    chk("t4_valid",  0, 32'(o_weight_valid), 32'd0);
    chk("t4_pe_en",  0, 32'(o_pe_en),        32'd0);
    chk("t4_data",   0, 32'(o_weight_data),  32'd0);
    chk("t4_row",    0, 32'(o_wr_w_row_ptr), 32'd0);
    chk("t4_col",    0, 32'(o_wr_w_col_ptr), 32'd0);
    chk("t4_busy",   0, 32'(o_busy),         32'd0);
    chk("t4_done",   0, 32'(o_done),         32'd0);
    chk("t4_wready", 0, 32'(o_wready),       32'd0);
    reset    = 1'b0;
    i_wvalid = 1'b0;
    do_load(3, 1, 16'h55, -1);

    // i_start with K=5 during a K=3 load is ignored
    do_load(3, 1, 16'h300, 4);

`ifdef WLOAD_BCAST_EN
    // Broadcast: K=2, N=4, data 7..10 to all four PEs at once
    tb_bcast = 1'b1;
    do_load(2, 4, 16'd7, -1);
    tb_bcast = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
